// File: rtl/rv32i_pkg.sv
// Shared RV32I decode constants: opcodes, funct fields, and the one-hot bit
// indices for the format class and ALU operation used by decode and execute.
package rv32i_pkg;

  localparam int TC_W  = 7;
  localparam int ALU_W = 10;

  // Opcodes (instr[6:0])
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;

  // type_code bit indices
  localparam int TC_R   = 0;
  localparam int TC_I   = 1;
  localparam int TC_S   = 2;
  localparam int TC_B   = 3;
  localparam int TC_U   = 4;
  localparam int TC_J   = 5;
  localparam int TC_ILL = 6;

  // alu_op bit indices
  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLL  = 2;
  localparam int ALU_SLT  = 3;
  localparam int ALU_SLTU = 4;
  localparam int ALU_XOR  = 5;
  localparam int ALU_SRL  = 6;
  localparam int ALU_SRA  = 7;
  localparam int ALU_OR   = 8;
  localparam int ALU_AND  = 9;

  // OP / OP-IMM funct3
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // BRANCH funct3
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [TC_W-1:0]  type_code;
    logic [ALU_W-1:0] alu_op;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
  } dec_t;

  // One-hot ALU op for the shared OP/OP-IMM funct3 map; alt picks SUB/SRA.
  function automatic logic [ALU_W-1:0] alu_from_funct3(input logic [2:0] f3,
                                                       input logic       alt);
    logic [ALU_W-1:0] v;
    v = '0;
    case (f3)
      F3_ADD_SUB: v[alt ? ALU_SUB : ALU_ADD] = 1'b1;
      F3_SLL:     v[ALU_SLL]  = 1'b1;
      F3_SLT:     v[ALU_SLT]  = 1'b1;
      F3_SLTU:    v[ALU_SLTU] = 1'b1;
      F3_XOR:     v[ALU_XOR]  = 1'b1;
      F3_SR:      v[alt ? ALU_SRA : ALU_SRL] = 1'b1;
      F3_OR:      v[ALU_OR]   = 1'b1;
      default:    v[ALU_AND]  = 1'b1;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/rv32i_decoder.sv
// Registered RV32I decoder: one-hot format class, one-hot ALU op and register
// indices, presented one cycle after the instruction word is sampled.
module rv32i_decoder
  import rv32i_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr,
  output logic [TC_W-1:0]   type_code,
  output logic [ALU_W-1:0]  alu_op,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2,
  output logic [4:0]        rd
);

  dec_t dec_d, dec_q;
  logic illegal;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    dec_d   = '0;
    illegal = 1'b0;

    case (opcode)
      OPC_OP: begin
        dec_d.type_code[TC_R] = 1'b1;
        dec_d.rs1 = instr[19:15];
        dec_d.rs2 = instr[24:20];
        dec_d.rd  = instr[11:7];
        if (funct7 == F7_BASE)
          dec_d.alu_op = alu_from_funct3(funct3, 1'b0);
        else if (funct7 == F7_ALT && (funct3 == F3_ADD_SUB || funct3 == F3_SR))
          dec_d.alu_op = alu_from_funct3(funct3, 1'b1);
        else
          illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        dec_d.type_code[TC_I] = 1'b1;
        dec_d.rs1 = instr[19:15];
        dec_d.rd  = instr[11:7];
        // No SUBI: bit 30 only distinguishes SRAI from SRLI.
        dec_d.alu_op = alu_from_funct3(funct3, (funct3 == F3_SR) && instr[30]);
      end
      OPC_LOAD, OPC_JALR: begin
        dec_d.type_code[TC_I] = 1'b1;
        dec_d.rs1 = instr[19:15];
        dec_d.rd  = instr[11:7];
        dec_d.alu_op[ALU_ADD] = 1'b1;
      end
      OPC_MISC_MEM, OPC_SYSTEM: begin
        dec_d.type_code[TC_I] = 1'b1;
        dec_d.rs1 = instr[19:15];
        dec_d.rd  = instr[11:7];
      end
      OPC_STORE: begin
        dec_d.type_code[TC_S] = 1'b1;
        dec_d.rs1 = instr[19:15];
        dec_d.rs2 = instr[24:20];
        dec_d.alu_op[ALU_ADD] = 1'b1;
      end
      OPC_BRANCH: begin
        dec_d.type_code[TC_B] = 1'b1;
        dec_d.rs1 = instr[19:15];
        dec_d.rs2 = instr[24:20];
        case (funct3)
          F3_BEQ, F3_BNE:   dec_d.alu_op[ALU_SUB]  = 1'b1;
          F3_BLT, F3_BGE:   dec_d.alu_op[ALU_SLT]  = 1'b1;
          F3_BLTU, F3_BGEU: dec_d.alu_op[ALU_SLTU] = 1'b1;
          default:          illegal = 1'b1;
        endcase
      end
      OPC_LUI, OPC_AUIPC: begin
        dec_d.type_code[TC_U] = 1'b1;
        dec_d.rd = instr[11:7];
        dec_d.alu_op[ALU_ADD] = 1'b1;
      end
      OPC_JAL: begin
        dec_d.type_code[TC_J] = 1'b1;
        dec_d.rd = instr[11:7];
        dec_d.alu_op[ALU_ADD] = 1'b1;
      end
      // Also catches any word with instr[1:0] != 2'b11.
      default: illegal = 1'b1;
    endcase

    if (illegal) begin
      dec_d = '0;
      dec_d.type_code[TC_ILL] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) dec_q <= '0;
    else     dec_q <= dec_d;
  end

  assign type_code = dec_q.type_code;
  assign alu_op    = dec_q.alu_op;
  assign rs1       = dec_q.rs1;
  assign rs2       = dec_q.rs2;
  assign rd        = dec_q.rd;

endmodule

// File: tb/tb_rv32i_decoder.sv
// Self-checking bench for rv32i_decoder: directed vectors, reset/latency
// behaviour and randomized words against a table-driven reference model.
module tb_rv32i_decoder;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic [6:0]  type_code;
  logic [9:0]  alu_op;
  logic [4:0]  rs1, rs2, rd;

  int checks = 0;
  int errors = 0;

  rv32i_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .instr     (instr),
    .type_code (type_code),
    .alu_op    (alu_op),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] I_SUB  = 32'h401101B3;
  localparam logic [31:0] I_OR   = 32'h0020E4B3;
  localparam logic [31:0] I_SLT  = 32'h00C3A0B3;
  localparam logic [31:0] E_SUB  = {7'h01, 10'h002, 5'd2, 5'd1,  5'd3};
  localparam logic [31:0] E_OR   = {7'h01, 10'h100, 5'd1, 5'd2,  5'd9};
  localparam logic [31:0] E_SLT  = {7'h01, 10'h008, 5'd7, 5'd12, 5'd1};
  localparam logic [31:0] E_ILL  = {7'h40, 25'd0};

  function automatic logic [31:0] observed();
    return {type_code, alu_op, rs1, rs2, rd};
  endfunction

  // Reference model: format letter from an opcode table, ALU op index from
  // per-format lookup tables, register fields from the format letter.
  function automatic logic [31:0] model(input logic [31:0] w);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    string      fmt;
    int         op;
    bit         ill;
    int         f3_map [8];
    int         br_map [8];
    logic [6:0] tc;
    logic [9:0] alu;
    logic [4:0] r1, r2, rdd;
    f3_map = '{0, 2, 3, 4, 5, 6, 8, 9};
    br_map = '{1, 1, -1, -1, 3, 3, 4, 4};
    opc = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    ill = 0; op = -1; fmt = "";
    case (opc)
      7'h33: begin
        fmt = "R";
        if (f7 == 7'h00)                   op = f3_map[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) op = 1;
        else if (f7 == 7'h20 && f3 == 3'd5) op = 7;
        else ill = 1;
      end
      7'h13: begin fmt = "I"; op = (f3 == 3'd5 && w[30]) ? 7 : f3_map[f3]; end
      7'h03, 7'h67: begin fmt = "I"; op = 0; end
      7'h0F, 7'h73: begin fmt = "I"; op = -1; end
      7'h23: begin fmt = "S"; op = 0; end
      7'h63: begin fmt = "B"; op = br_map[f3]; if (op < 0) ill = 1; end
      7'h37, 7'h17: begin fmt = "U"; op = 0; end
      7'h6F: begin fmt = "J"; op = 0; end
      default: ill = 1;
    endcase
    if (ill) return E_ILL;
    tc = '0;
    case (fmt)
      "R": tc[0] = 1'b1;
      "I": tc[1] = 1'b1;
      "S": tc[2] = 1'b1;
      "B": tc[3] = 1'b1;
      "U": tc[4] = 1'b1;
      default: tc[5] = 1'b1;
    endcase
    alu = '0;
    if (op >= 0) alu[op] = 1'b1;
    r1  = (fmt == "R" || fmt == "I" || fmt == "S" || fmt == "B") ? w[19:15] : 5'd0;
    r2  = (fmt == "R" || fmt == "S" || fmt == "B") ? w[24:20] : 5'd0;
    rdd = (fmt == "R" || fmt == "I" || fmt == "U" || fmt == "J") ? w[11:7] : 5'd0;
    return {tc, alu, r1, r2, rdd};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  opcs [11];
    logic [31:0] w;
    int          k;
    opcs = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h0F, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
    w = $urandom;
    k = $urandom_range(0, 14);
    if (k < 11) w[6:0] = opcs[k];
    if (w[6:0] == 7'h33) begin
      case ($urandom_range(0, 3))
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        default: ;
      endcase
    end
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    instr = I_SUB;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (observed() !== 32'd0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got %h want %h", i, observed(), 32'd0);
      end
    end
    rst = 1'b0;
    #2;
    checks++;
    if (observed() !== 32'd0) begin
      errors++;
      $display("FAIL reset_release_pre_edge: got %h want %h", observed(), 32'd0);
    end
    step();
    checks++;
    if (observed() !== E_SUB) begin
      errors++;
      $display("FAIL reset_release_first_decode: got %h want %h", observed(), E_SUB);
    end
  endtask

  task automatic test_directed();
    logic [31:0] vin [8];
    logic [31:0] vexp [8];
    string       vname [8];
    vin   = '{I_SUB, I_OR, I_SLT, 32'h40335293, 32'h0020A023, 32'h0020E063,
              32'hFFFFFFFF, 32'h00000000};
    vexp  = '{E_SUB, E_OR, E_SLT,
              {7'h02, 10'h080, 5'd6, 5'd0, 5'd5},
              {7'h04, 10'h001, 5'd1, 5'd2, 5'd0},
              {7'h08, 10'h010, 5'd1, 5'd2, 5'd0},
              E_ILL, E_ILL};
    vname = '{"sub", "or", "slt", "srai", "sw", "bltu", "ill_ones", "ill_zero"};
    for (int i = 0; i < 8; i++) begin
      instr = vin[i];
      step();
      checks++;
      if (observed() !== vexp[i]) begin
        errors++;
        $display("FAIL directed_%s: instr %h got %h want %h", vname[i], vin[i], observed(), vexp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] seq_in [3];
    logic [31:0] seq_exp [3];
    logic [31:0] prev;
    seq_in  = '{I_SUB, I_OR, I_SLT};
    seq_exp = '{E_SUB, E_OR, E_SLT};
    instr = 32'h0;
    step();
    prev = E_ILL;
    for (int i = 0; i < 3; i++) begin
      instr = seq_in[i];
      #2;
      checks++;
      if (observed() !== prev) begin
        errors++;
        $display("FAIL b2b_pre_edge[%0d]: got %h want %h", i, observed(), prev);
      end
      step();
      checks++;
      if (observed() !== seq_exp[i]) begin
        errors++;
        $display("FAIL b2b_post_edge[%0d]: got %h want %h", i, observed(), seq_exp[i]);
      end
      prev = seq_exp[i];
    end
  endtask

  task automatic test_midstream_reset();
    instr = I_OR;
    step();
    rst = 1'b1;
    instr = I_SLT;
    step();
    checks++;
    if (observed() !== 32'd0) begin
      errors++;
      $display("FAIL midstream_reset_discard: got %h want %h", observed(), 32'd0);
    end
    rst = 1'b0;
    instr = I_SUB;
    step();
    checks++;
    if (observed() !== E_SUB) begin
      errors++;
      $display("FAIL midstream_reset_resume: got %h want %h", observed(), E_SUB);
    end
  endtask

  task automatic test_random();
    logic [31:0] w;
    logic [31:0] want;
    for (int i = 0; i < 400; i++) begin
      w = rand_instr();
      instr = w;
      want = model(w);
      step();
      checks++;
      if (observed() !== want) begin
        errors++;
        $display("FAIL random[%0d]: instr %h got %h want %h", i, w, observed(), want);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    instr = 32'h0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_midstream_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32i_decoder.md
# rv32i_decoder

Registered RV32I instruction decoder for the execute front-end. Each cycle it accepts a 32-bit instruction word. One clock later it presents three things: a one-hot instruction-format class, a one-hot ALU operation, and the rs1/rs2/rd register indices. It sits between instruction fetch and the register file / ALU.

## Interface
Parameters: none.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- instr  input  32  instruction word, sampled every rising edge
- type_code  output  7  one-hot format class: [0] R, [1] I, [2] S, [3] B, [4] U, [5] J, [6] illegal
- alu_op  output  10  one-hot ALU op: [0] ADD, [1] SUB, [2] SLL, [3] SLT, [4] SLTU, [5] XOR, [6] SRL, [7] SRA, [8] OR, [9] AND
- rs1  output  5  source register 1 index
- rs2  output  5  source register 2 index
- rd  output  5  destination register index

## Operation
- Opcode instr[6:0] sets the class:
  - 0110011 → R
  - 0010011, 0000011, 1100111, 0001111, 1110011 → I
  - 0100011 → S
  - 1100011 → B
  - 0110111, 0010111 → U
  - 1101111 → J
  - any other opcode, or instr[1:0]≠11 → illegal
- R-type ALU op from {funct7[5], funct3}:
  - 0/000 ADD, 1/000 SUB
  - 0/001 SLL, 0/010 SLT, 0/011 SLTU, 0/100 XOR
  - 0/101 SRL, 1/101 SRA
  - 0/110 OR, 0/111 AND
- R-type is illegal if funct7 ∉ {0000000, 0100000}, or if funct7=0100000 with funct3 ∉ {000, 101}.
- OP-IMM (0010011) uses the same funct3 map. There is no SUBI. For funct3=101, instr[30] selects SRAI vs SRLI.
- Fixed ALU ops by opcode:
  - Loads, stores, JALR, AUIPC, LUI, JAL → ADD
  - FENCE/SYSTEM → alu_op all-zero
- Branches: BEQ/BNE → SUB; BLT/BGE → SLT; BLTU/BGEU → SLTU. Branch funct3 010/011 → illegal.
- Register fields:
  - rs1 = instr[19:15] for R/I/S/B
  - rs2 = instr[24:20] for R/S/B
  - rd = instr[11:7] for R/I/U/J
  - Any field unused by the format is driven 0.
- Illegal output: type_code=7'h40; alu_op, rs1, rs2, rd all 0.
- Exactly one type_code bit is set at all times outside reset. At most one alu_op bit is set.

## Timing
- Decode is combinational; all outputs are registered. Latency is 1 cycle: instr sampled at edge N appears on the outputs after edge N.
- A new instruction is accepted every cycle. There is no handshake and no stall input.
- rst high at a rising edge: all outputs become 0 (type_code=0, alu_op=0, rs1=rs2=rd=0). This holds regardless of instr.
- Reset asserted mid-stream discards the instruction sampled at that edge.
- The first decode appears one edge after rst deasserts.

## Structure
- Shared package rv32i_pkg holds:
  - opcode localparams
  - type_code bit indices (TC_R … TC_ILL)
  - alu_op bit indices (ALU_ADD … ALU_AND)
  - the funct3 constants
- The ALU/execute stages import the same indices.
- Single module containing one combinational always block and one output register block. No sub-module is needed.

## Test plan
- SUB 0x401101B3 → type_code 7'h01, alu_op 10'h002, rs1=2, rs2=1, rd=3.
- OR 0x0020E4B3 → type_code 7'h01, alu_op 10'h100, rs1=1, rs2=2, rd=9.
- SLT 0x00C3A0B3 → type_code 7'h01, alu_op 10'h008, rs1=7, rs2=12, rd=1.
- Format and zeroing checks:
  - SRAI x5,x6,3 (0x40335293) → 7'h02, 10'h080, rs1=6, rs2=0, rd=5
  - SW x2,0(x1) (0x0020A023) → 7'h04, 10'h001, rs1=1, rs2=2, rd=0
  - BLTU (0x0020E063) → 7'h08, 10'h010, rs1=1, rs2=2, rd=0
- Illegal inputs 0xFFFFFFFF and 0x00000000 → type_code 7'h40, all other outputs 0.
- Reset and latency:
  - Hold rst=1 while driving SUB → outputs stay 0.
  - Release rst → SUB decode appears exactly one edge later.
  - Back-to-back SUB/OR/SLT on consecutive cycles → each result appears exactly one cycle after its input.
